// File: rtl/axi_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_bus_pkg
// Shared types for the cache-to-AXI arbiter: FSM encoding, master indices,
// and the request/response bundles exchanged with the AXI bridge.
// Revision: 1.0
// ---------------------------------------------------------------------------
package axi_bus_pkg;

   localparam int M_ICACHE = 0;
   localparam int M_DCACHE = 1;
   localparam int LENS_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Everything a master drives toward the bridge
   typedef struct packed {
      logic [31:0]       addr;
      logic              addr_valid;
      logic              we;
      logic [2:0]        size;
      logic [LENS_W-1:0] lens;
      logic              rd_rready;
      logic              response_rready;
      logic [31:0]       wr_data;
      logic [3:0]        byte_enable;
      logic              wr_dready;
      logic              wr_last;
   } bus_req_t;

   // Everything the bridge drives back toward a master
   typedef struct packed {
      logic              rd_dready;
      logic              rd_last;
      logic [31:0]       rd_data;
      logic              rd_addr_clear;
      logic              wr_addr_clear;
      logic              wr_next;
      logic              wr_ok;
   } bus_rsp_t;

endpackage
`default_nettype wire

// File: rtl/axi_bus_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_bus_mux
// Grant-indexed mux of master requests onto the bus and demux of bus
// responses back to the owner only. Purely combinational.
// Revision: 1.0
// ---------------------------------------------------------------------------
module axi_bus_mux
   import axi_bus_pkg::*;
(
   input  logic [1:0] grant,
   input  bus_req_t   m0_req,
   input  bus_req_t   m1_req,
   output bus_req_t   bus_req,
   input  bus_rsp_t   bus_rsp,
   output bus_rsp_t   m0_rsp,
   output bus_rsp_t   m1_rsp
);

   // Owner drives the bus and alone sees the responses; idle means all zero
   always_comb begin
      bus_req = '0;
      m0_rsp  = '0;
      m1_rsp  = '0;
      if (grant[M_ICACHE]) begin
         bus_req = m0_req;
         m0_rsp  = bus_rsp;
      end else if (grant[M_DCACHE]) begin
         bus_req = m1_req;
         m1_rsp  = bus_rsp;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cache_axi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_axi_arbiter
// Shares the AXI bridge between icache (master 0) and dcache (master 1),
// granting one whole transaction at a time. Round-robin or fixed priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cache_axi_arbiter
   import axi_bus_pkg::*;
#(
   parameter bit PRIO_MODE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       m0_addr,
   input  logic              m0_addr_valid,
   input  logic              m0_we,
   input  logic [2:0]        m0_size,
   input  logic [LENS_W-1:0] m0_lens,
   input  logic              m0_rd_rready,
   input  logic              m0_response_rready,
   input  logic [31:0]       m0_wr_data,
   input  logic [3:0]        m0_byte_enable,
   input  logic              m0_wr_dready,
   input  logic              m0_wr_last,
   output logic              m0_rd_dready,
   output logic              m0_rd_last,
   output logic [31:0]       m0_rd_data,
   output logic              m0_rd_addr_clear,
   output logic              m0_wr_addr_clear,
   output logic              m0_wr_next,
   output logic              m0_wr_ok,
   input  logic [31:0]       m1_addr,
   input  logic              m1_addr_valid,
   input  logic              m1_we,
   input  logic [2:0]        m1_size,
   input  logic [LENS_W-1:0] m1_lens,
   input  logic              m1_rd_rready,
   input  logic              m1_response_rready,
   input  logic [31:0]       m1_wr_data,
   input  logic [3:0]        m1_byte_enable,
   input  logic              m1_wr_dready,
   input  logic              m1_wr_last,
   output logic              m1_rd_dready,
   output logic              m1_rd_last,
   output logic [31:0]       m1_rd_data,
   output logic              m1_rd_addr_clear,
   output logic              m1_wr_addr_clear,
   output logic              m1_wr_next,
   output logic              m1_wr_ok,
   output logic [31:0]       AXI_addr,
   output logic              AXI_addr_valid,
   output logic              AXI_we,
   output logic [2:0]        AXI_size,
   output logic [LENS_W-1:0] AXI_lens,
   output logic              AXI_rd_rready,
   output logic              AXI_response_rready,
   output logic [31:0]       AXI_wr_data,
   output logic [3:0]        AXI_byte_enable,
   output logic              AXI_wr_dready,
   output logic              AXI_wr_last,
   input  logic              AXI_rd_dready,
   input  logic              AXI_rd_last,
   input  logic [31:0]       AXI_rd_data,
   input  logic              AXI_rd_addr_clear,
   input  logic              AXI_wr_next,
   input  logic              AXI_wr_ok,
   input  logic              AXI_wr_addr_clear,
   output logic [1:0]        grant,
   output logic              err_len
);

   bus_req_t          m0_req, m1_req, bus_req;
   bus_rsp_t          bus_rsp, m0_rsp, m1_rsp;
   state_t            state, next_state;
   logic [1:0]        next_grant;
   logic              lat_we, next_we;
   logic [LENS_W-1:0] lat_lens, next_lens;
   logic              last_owner, next_last_owner;
   logic [8:0]        beat_cnt, next_beat_cnt;
   logic              next_err_len;
   logic              pick_m1;
   logic              rd_beat;

   assign m0_req = '{addr: m0_addr, addr_valid: m0_addr_valid, we: m0_we, size: m0_size,
                     lens: m0_lens, rd_rready: m0_rd_rready,
                     response_rready: m0_response_rready, wr_data: m0_wr_data,
                     byte_enable: m0_byte_enable, wr_dready: m0_wr_dready,
                     wr_last: m0_wr_last};
   assign m1_req = '{addr: m1_addr, addr_valid: m1_addr_valid, we: m1_we, size: m1_size,
                     lens: m1_lens, rd_rready: m1_rd_rready,
                     response_rready: m1_response_rready, wr_data: m1_wr_data,
                     byte_enable: m1_byte_enable, wr_dready: m1_wr_dready,
                     wr_last: m1_wr_last};
   assign bus_rsp = '{rd_dready: AXI_rd_dready, rd_last: AXI_rd_last, rd_data: AXI_rd_data,
                      rd_addr_clear: AXI_rd_addr_clear, wr_addr_clear: AXI_wr_addr_clear,
                      wr_next: AXI_wr_next, wr_ok: AXI_wr_ok};

   axi_bus_mux u_mux (
      .grant   (grant),
      .m0_req  (m0_req),
      .m1_req  (m1_req),
      .bus_req (bus_req),
      .bus_rsp (bus_rsp),
      .m0_rsp  (m0_rsp),
      .m1_rsp  (m1_rsp)
   );

   assign AXI_addr            = bus_req.addr;
   assign AXI_addr_valid      = bus_req.addr_valid;
   assign AXI_we              = bus_req.we;
   assign AXI_size            = bus_req.size;
   assign AXI_lens            = bus_req.lens;
   assign AXI_rd_rready       = bus_req.rd_rready;
   assign AXI_response_rready = bus_req.response_rready;
   assign AXI_wr_data         = bus_req.wr_data;
   assign AXI_byte_enable     = bus_req.byte_enable;
   assign AXI_wr_dready       = bus_req.wr_dready;
   assign AXI_wr_last         = bus_req.wr_last;

   assign m0_rd_dready     = m0_rsp.rd_dready;
   assign m0_rd_last       = m0_rsp.rd_last;
   assign m0_rd_data       = m0_rsp.rd_data;
   assign m0_rd_addr_clear = m0_rsp.rd_addr_clear;
   assign m0_wr_addr_clear = m0_rsp.wr_addr_clear;
   assign m0_wr_next       = m0_rsp.wr_next;
   assign m0_wr_ok         = m0_rsp.wr_ok;
   assign m1_rd_dready     = m1_rsp.rd_dready;
   assign m1_rd_last       = m1_rsp.rd_last;
   assign m1_rd_data       = m1_rsp.rd_data;
   assign m1_rd_addr_clear = m1_rsp.rd_addr_clear;
   assign m1_wr_addr_clear = m1_rsp.wr_addr_clear;
   assign m1_wr_next       = m1_rsp.wr_next;
   assign m1_wr_ok         = m1_rsp.wr_ok;

   // A read beat counts only when the owner is ready to take it
   assign rd_beat = AXI_rd_dready & bus_req.rd_rready;

   // Choose the winner of an idle-time request; ties go to priority or to the
   // master that did not own the last completed transaction
   always_comb begin
      pick_m1 = m1_addr_valid;
      if (m0_addr_valid && m1_addr_valid) begin
         pick_m1 = PRIO_MODE ? 1'b1 : ~last_owner;
      end
   end

   // Next-state, grant, latch and beat-count logic
   always_comb begin
      next_state      = state;
      next_grant      = grant;
      next_we         = lat_we;
      next_lens       = lat_lens;
      next_last_owner = last_owner;
      next_beat_cnt   = beat_cnt;
      next_err_len    = err_len;
      case (state)
         ST_IDLE: begin
            if (m0_addr_valid || m1_addr_valid) begin
               next_state = ST_ADDR;
               next_grant = pick_m1 ? 2'b10 : 2'b01;
               next_we    = pick_m1 ? m1_we : m0_we;
               next_lens  = pick_m1 ? m1_lens : m0_lens;
            end
         end
         ST_ADDR: begin
            if (lat_we ? AXI_wr_addr_clear : AXI_rd_addr_clear) begin
               next_state    = ST_DATA;
               next_beat_cnt = '0;
            end else if (!bus_req.addr_valid) begin
               // Cache abandoned its request; nothing completed
               next_state = ST_IDLE;
               next_grant = 2'b00;
            end
         end
         ST_DATA: begin
            if (!lat_we) begin
               if (rd_beat) begin
                  next_beat_cnt = beat_cnt + 9'd1;
                  if (AXI_rd_last) begin
                     next_state      = ST_IDLE;
                     next_grant      = 2'b00;
                     next_last_owner = grant[M_DCACHE];
                     if ((beat_cnt + 9'd1) != ({1'b0, lat_lens} + 9'd1)) begin
                        next_err_len = 1'b1;
                     end
                  end
               end
            end else if (AXI_wr_ok) begin
               next_state      = ST_IDLE;
               next_grant      = 2'b00;
               next_last_owner = grant[M_DCACHE];
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_grant = 2'b00;
         end
      endcase
   end

   // State and bookkeeping registers; reset drops the grant immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         grant      <= 2'b00;
         lat_we     <= 1'b0;
         lat_lens   <= '0;
         last_owner <= 1'b1;
         beat_cnt   <= '0;
         err_len    <= 1'b0;
      end else begin
         state      <= next_state;
         grant      <= next_grant;
         lat_we     <= next_we;
         lat_lens   <= next_lens;
         last_owner <= next_last_owner;
         beat_cnt   <= next_beat_cnt;
         err_len    <= next_err_len;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_arbiter.sv
`timescale 1ns/1ps
// Bench for cache_axi_arbiter: round-robin instance [0] and fixed-priority
// instance [1] share stimulus; sel picks which one the monitor watches.
module tb_cache_axi_arbiter;

   localparam int EV_GRANT = 0;
   localparam int EV_RD0   = 1;
   localparam int EV_RD1   = 2;
   localparam int EV_WBEAT = 3;
   localparam int EV_WOK0  = 4;
   localparam int EV_WOK1  = 5;

   typedef struct {
      int          kind;
      logic [63:0] val;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m0_addr, m1_addr, m0_wr_data, m1_wr_data;
   logic        m0_addr_valid, m1_addr_valid, m0_we, m1_we;
   logic [2:0]  m0_size, m1_size;
   logic [7:0]  m0_lens, m1_lens;
   logic        m0_rd_rready, m1_rd_rready, m0_response_rready, m1_response_rready;
   logic [3:0]  m0_byte_enable, m1_byte_enable;
   logic        m0_wr_dready, m1_wr_dready, m0_wr_last, m1_wr_last;
   logic        bus_rd_dready, bus_rd_last, bus_rd_addr_clear;
   logic        bus_wr_next, bus_wr_ok, bus_wr_addr_clear;
   logic [31:0] bus_rd_data;

   logic        dut_m0_rd_dready[2], dut_m0_rd_last[2], dut_m0_rd_addr_clear[2];
   logic        dut_m0_wr_addr_clear[2], dut_m0_wr_next[2], dut_m0_wr_ok[2];
   logic        dut_m1_rd_dready[2], dut_m1_rd_last[2], dut_m1_rd_addr_clear[2];
   logic        dut_m1_wr_addr_clear[2], dut_m1_wr_next[2], dut_m1_wr_ok[2];
   logic [31:0] dut_m0_rd_data[2], dut_m1_rd_data[2];
   logic [31:0] dut_axi_addr[2], dut_axi_wr_data[2];
   logic        dut_axi_addr_valid[2], dut_axi_we[2], dut_axi_rd_rready[2];
   logic        dut_axi_response_rready[2], dut_axi_wr_dready[2], dut_axi_wr_last[2];
   logic [2:0]  dut_axi_size[2];
   logic [7:0]  dut_axi_lens[2];
   logic [3:0]  dut_axi_byte_enable[2];
   logic [1:0]  dut_grant[2];
   logic        dut_err_len[2];

   int   sel = 0;
   int   checks = 0;
   int   errors = 0;
   int   e;
   ev_t  exp_q[$];
   logic [1:0] prev_grant = 2'b00;

   for (genvar i = 0; i < 2; i++) begin : g_dut
      cache_axi_arbiter #(.PRIO_MODE(i == 1)) dut (
         .clk(clk), .rst(rst),
         .m0_addr(m0_addr), .m0_addr_valid(m0_addr_valid), .m0_we(m0_we),
         .m0_size(m0_size), .m0_lens(m0_lens), .m0_rd_rready(m0_rd_rready),
         .m0_response_rready(m0_response_rready), .m0_wr_data(m0_wr_data),
         .m0_byte_enable(m0_byte_enable), .m0_wr_dready(m0_wr_dready), .m0_wr_last(m0_wr_last),
         .m0_rd_dready(dut_m0_rd_dready[i]), .m0_rd_last(dut_m0_rd_last[i]),
         .m0_rd_data(dut_m0_rd_data[i]), .m0_rd_addr_clear(dut_m0_rd_addr_clear[i]),
         .m0_wr_addr_clear(dut_m0_wr_addr_clear[i]), .m0_wr_next(dut_m0_wr_next[i]),
         .m0_wr_ok(dut_m0_wr_ok[i]),
         .m1_addr(m1_addr), .m1_addr_valid(m1_addr_valid), .m1_we(m1_we),
         .m1_size(m1_size), .m1_lens(m1_lens), .m1_rd_rready(m1_rd_rready),
         .m1_response_rready(m1_response_rready), .m1_wr_data(m1_wr_data),
         .m1_byte_enable(m1_byte_enable), .m1_wr_dready(m1_wr_dready), .m1_wr_last(m1_wr_last),
         .m1_rd_dready(dut_m1_rd_dready[i]), .m1_rd_last(dut_m1_rd_last[i]),
         .m1_rd_data(dut_m1_rd_data[i]), .m1_rd_addr_clear(dut_m1_rd_addr_clear[i]),
         .m1_wr_addr_clear(dut_m1_wr_addr_clear[i]), .m1_wr_next(dut_m1_wr_next[i]),
         .m1_wr_ok(dut_m1_wr_ok[i]),
         .AXI_addr(dut_axi_addr[i]), .AXI_addr_valid(dut_axi_addr_valid[i]),
         .AXI_we(dut_axi_we[i]), .AXI_size(dut_axi_size[i]), .AXI_lens(dut_axi_lens[i]),
         .AXI_rd_rready(dut_axi_rd_rready[i]), .AXI_response_rready(dut_axi_response_rready[i]),
         .AXI_wr_data(dut_axi_wr_data[i]), .AXI_byte_enable(dut_axi_byte_enable[i]),
         .AXI_wr_dready(dut_axi_wr_dready[i]), .AXI_wr_last(dut_axi_wr_last[i]),
         .AXI_rd_dready(bus_rd_dready), .AXI_rd_last(bus_rd_last), .AXI_rd_data(bus_rd_data),
         .AXI_rd_addr_clear(bus_rd_addr_clear), .AXI_wr_next(bus_wr_next),
         .AXI_wr_ok(bus_wr_ok), .AXI_wr_addr_clear(bus_wr_addr_clear),
         .grant(dut_grant[i]), .err_len(dut_err_len[i])
      );
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [63:0] val);
      ev_t ev;
      ev.kind = kind;
      ev.val  = val;
      exp_q.push_back(ev);
   endtask

   task automatic sb_pop(input int kind, input logic [63:0] val);
      ev_t ev;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_event: got kind %0d value %h, expected nothing", kind, val);
      end else begin
         ev = exp_q.pop_front();
         if (ev.kind != kind || ev.val !== val) begin
            errors++;
            $display("FAIL sb_event: got kind %0d value %h, expected kind %0d value %h",
                     kind, val, ev.kind, ev.val);
         end
      end
   endtask

   // Monitor: every observable event of the watched DUT is popped and compared
   always @(negedge clk) begin
      if (rst) begin
         if (prev_grant == 2'b00 && dut_grant[sel] != 2'b00)
            sb_pop(EV_GRANT, {62'd0, dut_grant[sel]});
         if (dut_m0_rd_dready[sel]) sb_pop(EV_RD0, {32'd0, dut_m0_rd_data[sel]});
         if (dut_m1_rd_dready[sel]) sb_pop(EV_RD1, {32'd0, dut_m1_rd_data[sel]});
         if (dut_axi_wr_dready[sel] && (dut_m0_wr_next[sel] || dut_m1_wr_next[sel]))
            sb_pop(EV_WBEAT, {28'd0, dut_axi_byte_enable[sel], dut_axi_wr_data[sel]});
         if (dut_m0_wr_ok[sel]) sb_pop(EV_WOK0, 64'd0);
         if (dut_m1_wr_ok[sel]) sb_pop(EV_WOK1, 64'd0);
      end
      prev_grant <= dut_grant[sel];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_addr = '0; m0_addr_valid = 0; m0_we = 0; m0_size = 3'd2; m0_lens = '0;
      m1_addr = '0; m1_addr_valid = 0; m1_we = 0; m1_size = 3'd2; m1_lens = '0;
      m0_rd_rready = 1; m1_rd_rready = 1; m0_response_rready = 1; m1_response_rready = 1;
      m0_wr_data = '0; m1_wr_data = '0; m0_byte_enable = '0; m1_byte_enable = '0;
      m0_wr_dready = 0; m1_wr_dready = 0; m0_wr_last = 0; m1_wr_last = 0;
      bus_rd_dready = 0; bus_rd_last = 0; bus_rd_data = '0; bus_rd_addr_clear = 0;
      bus_wr_next = 0; bus_wr_ok = 0; bus_wr_addr_clear = 0;
   endtask

   // Hold reset with live inputs to show every output is forced to zero
   task automatic do_reset(input int s);
      rst = 0;
      clear_inputs();
      m0_addr_valid = 1; m0_lens = 8'h05; bus_rd_dready = 1; bus_wr_ok = 1;
      #1;
      sel = s;
      tick();
      chk("rst_grant", {62'd0, dut_grant[s]}, 64'd0);
      chk("rst_axi_addr_valid", {63'd0, dut_axi_addr_valid[s]}, 64'd0);
      chk("rst_axi_lens", {56'd0, dut_axi_lens[s]}, 64'd0);
      chk("rst_m0_rd_dready", {63'd0, dut_m0_rd_dready[s]}, 64'd0);
      chk("rst_m0_wr_ok", {63'd0, dut_m0_wr_ok[s]}, 64'd0);
      chk("rst_err_len", {63'd0, dut_err_len[s]}, 64'd0);
      clear_inputs();
      rst = 1;
   endtask

   // Called in ADDR with master m granted; finishes the read and lands in IDLE
   task automatic run_read(input int m, input int beats, input logic [31:0] base);
      bus_rd_addr_clear = 1;
      #1;
      chk("rd_clear_owner", {63'd0, (m == 1) ? dut_m1_rd_addr_clear[sel] : dut_m0_rd_addr_clear[sel]}, 64'd1);
      chk("rd_clear_nonowner", {63'd0, (m == 1) ? dut_m0_rd_addr_clear[sel] : dut_m1_rd_addr_clear[sel]}, 64'd0);
      tick();
      bus_rd_addr_clear = 0;
      if (m == 0) m0_addr_valid = 0; else m1_addr_valid = 0;
      for (int i = 0; i < beats; i++) begin
         bus_rd_dready = 1;
         bus_rd_data   = base + 32'(i);
         bus_rd_last   = (i == beats - 1);
         push_ev((m == 1) ? EV_RD1 : EV_RD0, {32'd0, base + 32'(i)});
         tick();
      end
      bus_rd_dready = 0;
      bus_rd_last   = 0;
      chk("idle_after_read", {62'd0, dut_grant[sel]}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      clear_inputs();

      // Single read, master 0, lens=7
      do_reset(0);
      push_ev(EV_GRANT, 64'd1);
      m0_addr = 32'h0000_1000; m0_lens = 8'd7; m0_addr_valid = 1;
      tick();
      chk("t1_grant", {62'd0, dut_grant[0]}, 64'd1);
      chk("t1_axi_addr", {32'd0, dut_axi_addr[0]}, 64'h1000);
      chk("t1_axi_lens", {56'd0, dut_axi_lens[0]}, 64'd7);
      run_read(0, 8, 32'hA000_0000);
      chk("t1_err_len", {63'd0, dut_err_len[0]}, 64'd0);

      // Round-robin ties: owners alternate 0,1,0,1 with one idle cycle between
      do_reset(0);
      m0_lens = 8'd1; m1_lens = 8'd1; m0_addr_valid = 1; m1_addr_valid = 1;
      for (int i = 0; i < 4; i++) begin
         e = i % 2;
         push_ev(EV_GRANT, (e == 1) ? 64'd2 : 64'd1);
         tick();
         chk("t2_grant", {62'd0, dut_grant[0]}, (e == 1) ? 64'd2 : 64'd1);
         run_read(e, 2, 32'hB000_0000 + 32'(i * 16));
         if (e == 0) m0_addr_valid = 1; else m1_addr_valid = 1;
      end
      m0_addr_valid = 0; m1_addr_valid = 0;

      // Fixed priority: master 1 wins while requesting, then master 0
      do_reset(1);
      m0_addr_valid = 1; m1_addr_valid = 1;
      for (int j = 0; j < 3; j++) begin
         push_ev(EV_GRANT, 64'd2);
         tick();
         chk("t3_grant_m1", {62'd0, dut_grant[1]}, 64'd2);
         run_read(1, 1, 32'hC000_0000 + 32'(j));
         if (j < 2) m1_addr_valid = 1;
      end
      push_ev(EV_GRANT, 64'd1);
      tick();
      chk("t3_grant_m0", {62'd0, dut_grant[1]}, 64'd1);
      run_read(0, 1, 32'hC000_0100);

      // Write from master 1, single beat, response gated by AXI_wr_ok
      do_reset(0);
      push_ev(EV_GRANT, 64'd2);
      m1_addr = 32'h0000_2000; m1_we = 1; m1_lens = 8'd0; m1_wr_data = 32'hDEADBEEF;
      m1_byte_enable = 4'b0011; m1_wr_dready = 1; m1_wr_last = 1; m1_addr_valid = 1;
      tick();
      chk("t4_grant", {62'd0, dut_grant[0]}, 64'd2);
      chk("t4_axi_we", {63'd0, dut_axi_we[0]}, 64'd1);
      chk("t4_axi_wr_data", {32'd0, dut_axi_wr_data[0]}, 64'hDEADBEEF);
      chk("t4_axi_byte_enable", {60'd0, dut_axi_byte_enable[0]}, 64'h3);
      bus_wr_addr_clear = 1;
      tick();
      bus_wr_addr_clear = 0; m1_addr_valid = 0; bus_wr_next = 1;
      push_ev(EV_WBEAT, {28'd0, 4'b0011, 32'hDEADBEEF});
      tick();
      bus_wr_next = 0; m1_wr_dready = 0; m1_wr_last = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_grant_held", {62'd0, dut_grant[0]}, 64'd2);
      end
      bus_wr_ok = 1;
      push_ev(EV_WOK1, 64'd0);
      #1;
      chk("t4_m0_wr_ok_blocked", {63'd0, dut_m0_wr_ok[0]}, 64'd0);
      tick();
      bus_wr_ok = 0; m1_we = 0;
      chk("t4_idle", {62'd0, dut_grant[0]}, 64'd0);

      // Master 0 abandons in ADDR; pending master 1 granted a cycle later
      push_ev(EV_GRANT, 64'd1);
      m0_lens = 8'd0; m0_addr_valid = 1;
      tick();
      chk("t5_grant_m0", {62'd0, dut_grant[0]}, 64'd1);
      m0_addr_valid = 0; m1_lens = 8'd0; m1_addr_valid = 1;
      tick();
      chk("t5_idle", {62'd0, dut_grant[0]}, 64'd0);
      push_ev(EV_GRANT, 64'd2);
      tick();
      chk("t5_grant_m1", {62'd0, dut_grant[0]}, 64'd2);
      run_read(1, 1, 32'hD000_0000);

      // Short burst sets sticky err_len
      push_ev(EV_GRANT, 64'd1);
      m0_lens = 8'd3; m0_addr_valid = 1;
      tick();
      run_read(0, 2, 32'hE000_0000);
      chk("t6_err_len_set", {63'd0, dut_err_len[0]}, 64'd1);
      push_ev(EV_GRANT, 64'd1);
      m0_lens = 8'd0; m0_addr_valid = 1;
      tick();
      run_read(0, 1, 32'hE000_0100);
      chk("t6_err_len_sticky", {63'd0, dut_err_len[0]}, 64'd1);

      // Reset mid-burst drops everything asynchronously
      push_ev(EV_GRANT, 64'd1);
      m0_lens = 8'd3; m0_addr_valid = 1;
      tick();
      bus_rd_addr_clear = 1;
      tick();
      bus_rd_addr_clear = 0; bus_rd_dready = 1; bus_rd_data = 32'hF000_0000;
      push_ev(EV_RD0, 64'hF000_0000);
      tick();
      bus_rd_data = 32'hF000_0001;
      rst = 0;
      #1;
      chk("t7_grant", {62'd0, dut_grant[0]}, 64'd0);
      chk("t7_m0_rd_dready", {63'd0, dut_m0_rd_dready[0]}, 64'd0);
      chk("t7_axi_addr_valid", {63'd0, dut_axi_addr_valid[0]}, 64'd0);
      chk("t7_axi_lens", {56'd0, dut_axi_lens[0]}, 64'd0);
      chk("t7_err_len", {63'd0, dut_err_len[0]}, 64'd0);
      clear_inputs();
      tick();
      rst = 1;
      tick();
      @(negedge clk);
      #1;
      chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Two-master arbiter that shares the single simplified-AXI bus bridge between the instruction cache (master 0) and the data cache/uncache path (master 1). Masters and bus use the codebase's handshake bundle: `addr_valid`/`*_addr_clear` for the address phase, `rd_dready`/`rd_last` for read beats, and `wr_next`/`wr_ok` for write beats and response. The arbiter grants one whole transaction at a time, from address phase to final read beat or write response, then re-arbitrates. It sits between the cache wrappers and the AXI bridge.

## Interface
- `PRIO_MODE`, default 0: 0 = round-robin; 1 = fixed priority, master 1 (data) wins.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `mN_addr`  in  32  master N (N=0,1) request address.
- `mN_addr_valid`  in  1  master N request.
- `mN_we`  in  1  write (1) or read (0).
- `mN_size`, `mN_lens`  in  3, 8  burst size and length (beats = lens+1).
- `mN_rd_rready`, `mN_response_rready`  in  1  master ready for read data and for write response.
- `mN_wr_data`, `mN_byte_enable`  in  32, 4  write beat and its byte enables.
- `mN_wr_dready`, `mN_wr_last`  in  1  write beat valid, and last beat.
- `mN_rd_dready`, `mN_rd_last`, `mN_rd_data`  out  1, 1, 32  read beat routed to the granted master, 0 otherwise.
- `mN_rd_addr_clear`, `mN_wr_addr_clear`, `mN_wr_next`, `mN_wr_ok`  out  1  bus responses routed to the granted master, 0 otherwise.
- `AXI_*`  out  bus-side copies of all master inputs above (same names and widths), driven from the granted master; all 0 when no master is granted.
- `AXI_rd_dready`, `AXI_rd_last`, `AXI_rd_data`, `AXI_rd_addr_clear`, `AXI_wr_next`, `AXI_wr_ok`, `AXI_wr_addr_clear`  in  bus responses.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `err_len`  out  1  sticky flag: a read burst ended with a beat count different from lens+1.

## Operation
- States:
  - IDLE: no owner.
  - ADDR: owner's address phase forwarded to the bus.
  - DATA: owner's data phase forwarded to the bus.
- IDLE, exactly one `mN_addr_valid`: load `grant` with that master, latch its `we` and `lens`, go to ADDR.
- IDLE, both `mN_addr_valid`:
  - `PRIO_MODE`=1: master 1 wins.
  - `PRIO_MODE`=0: the master that did not own the last completed transaction wins. `last_owner` resets to 1, so master 0 wins the first tie.
- ADDR:
  - Latched read and `AXI_rd_addr_clear`: go to DATA.
  - Latched write and `AXI_wr_addr_clear`: go to DATA.
  - Owner drops `addr_valid` before clear (cache abandoned its request): go to IDLE, no completion recorded, `last_owner` unchanged.
- DATA: grant is held regardless of `addr_valid`. A read completes on `AXI_rd_dready & AXI_rd_last & owner rd_rready`. A write completes on `AXI_wr_ok`. On completion, set `last_owner` and go to IDLE.
- Beat counter: 9 bits, cleared on entering DATA, incremented per accepted read beat. At completion, if counter+1 ≠ latched lens+1, set `err_len`. `err_len` is cleared only by reset.
- Routing is combinational from the `grant` register: bus outputs mux from the owner; response inputs go to the owner only, and the non-owner sees 0.

## Timing
- Reset (asynchronous assert) forces:
  - state = IDLE, `grant` = 00, `last_owner` = 1, counter = 0, `err_len` = 0.
  - all `AXI_*` outputs and all `mN_*` outputs = 0.
- Arbitration latency is 1 cycle: request sampled at edge k gives `grant` and `AXI_addr_valid` valid after edge k.
- Completion at edge k gives IDLE after edge k. The earliest next grant is after edge k+1, so there is always one idle bus cycle between owners.
- A request arriving while the other master owns the bus waits. Its `addr_valid` must stay held; it sees `mN_*_addr_clear` = 0 throughout.
- Reset mid-burst drops the grant immediately. The bridge is reset by the same `rst`.
- A completion and a new request from the same master in the same cycle: the completion wins, and the new request is arbitrated from IDLE.

## Structure
- Shared package `axi_bus_pkg`: state encoding (IDLE/ADDR/DATA), master index constants `M_ICACHE`=0 and `M_DCACHE`=1, and a bundle width constant for `lens` (8).
- One natural sub-module: `axi_bus_mux`, a purely combinational grant-indexed mux and demux of the bundle. FSM, counter and priority logic stay in the top. Expected size is about 200 lines total.

## Test plan
- Single read, master 0, lens=7: grant=01 one cycle after request; 8 beats routed to `m0_rd_data`; `m1_rd_dready` stays 0; IDLE after the last beat; `err_len`=0.
- Simultaneous requests, `PRIO_MODE`=0, repeated 4 times: owners alternate 0,1,0,1, with one idle cycle between bursts.
- `PRIO_MODE`=1, master 0 and master 1 both continuously requesting: master 1 is granted every time; master 0 is granted only after master 1 deasserts.
- Write, master 1, lens=0, data 0xDEADBEEF, byte enable 4'b0011: `AXI_wr_data`/`AXI_byte_enable` match; grant is held until `AXI_wr_ok`; `m1_wr_ok` pulses once.
- Master 0 drops `addr_valid` in ADDR before `AXI_rd_addr_clear`: back to IDLE next cycle; a pending master 1 request is granted one cycle later.
- Read with lens=3 but `AXI_rd_last` on beat 2: `err_len`=1, sticky. Assert `rst` low mid-burst: all outputs are 0 asynchronously.
